// File: rtl/cvxif_pkg.sv
`default_nettype none
// ==== cvxif_pkg : shared types/constants for the conv accelerator datapath ==== rev 1.0
package cvxif_pkg;
  localparam int SA_LANES = 9;
  typedef logic signed [7:0] sa_operand_t;
endpackage
`default_nettype wire

// File: rtl/sa_input_skew_lane.sv
`default_nettype none
// ==== sa_skew_lane : DEPTH-stage {valid,data} delay line, data zeroed on bubbles ==== rev 1.0
module sa_skew_lane #(
  parameter int DEPTH = 1,
  parameter int DW    = 8
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_clr,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  output logic [DW-1:0] o_data
);

  logic [DEPTH-1:0]         vld_q, vld_d;
  logic [DEPTH-1:0][DW-1:0] dat_q, dat_d;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    for (int s = DEPTH - 1; s > 0; s--) begin
      vld_d[s] = vld_q[s-1];
      dat_d[s] = dat_q[s-1];
    end
    // Zero data on entry so an invalid slot can never carry stale operands downstream.
    vld_d[0] = i_valid;
    dat_d[0] = i_valid ? i_data : '0;
    if (i_clr) begin
      vld_d = '0;
      dat_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign o_valid = vld_q[DEPTH-1];
  assign o_data  = dat_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/sa_input_skew.sv
`default_nettype none
// ==== sa_input_skew : diagonal skew of im2col beats onto systolic-array rows ==== rev 1.0
module sa_input_skew
  import cvxif_pkg::*;
#(
  parameter int LANES = SA_LANES,
  parameter int DW    = 8,
  parameter int CNT_W = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rstn,
  input  logic                      i_start,
  input  logic                      i_valid,
  input  logic [LANES-1:0][DW-1:0]  i_data,
  input  logic                      i_last,
  output logic [LANES-1:0][DW-1:0]  o_data,
  output logic [LANES-1:0]          o_valid,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [CNT_W-1:0]          o_beats
);

  localparam int CW = $clog2(LANES + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    gap_q, gap_d;
  logic [CNT_W-1:0] beats_q, beats_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             w_accept;
  logic [CW-1:0]    w_drain_load;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // gap_q counts cycles since the last accepted beat, so a late i_last still times
  // o_done to the moment that beat leaves the deepest lane.
  always_comb begin
    if (i_valid)                                             w_drain_load = CW'(LANES - 1);
    else if (beats_q == '0 || gap_q >= CW'(LANES - 2))       w_drain_load = '0;
    else                                                     w_drain_load = CW'(LANES - 2) - gap_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) state_d = S_STREAM;
      end
      S_STREAM: begin
        if (i_start) begin
          state_d = S_STREAM;
        end else if (i_last) begin
          state_d = S_DRAIN;
          cnt_d   = w_drain_load;
        end
      end
      S_DRAIN: begin
        if (i_start)            state_d = S_STREAM;
        else if (cnt_q == '0)   state_d = S_IDLE;
        else                    cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    w_accept = (state_q == S_STREAM) && i_valid && !i_start;
    beats_d  = beats_q;
    gap_d    = gap_q;
    if (i_start) begin
      beats_d = '0;
      gap_d   = CW'(LANES);
    end else if (w_accept) begin
      if (beats_q != '1) beats_d = beats_q + CNT_W'(1);
      gap_d = '0;
    end else if (gap_q != CW'(LANES)) begin
      gap_d = gap_q + CW'(1);
    end
    done_d = (state_d == S_DRAIN) && (cnt_d == '0);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt_q   <= '0;
      gap_q   <= '0;
      beats_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      beats_q <= beats_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    sa_skew_lane #(
      .DEPTH (k + 1),
      .DW    (DW)
    ) u_lane (
      .i_clk   (i_clk),
      .i_rstn  (i_rstn),
      .i_clr   (i_start),
      .i_valid (w_accept),
      .i_data  (i_data[k]),
      .o_valid (o_valid[k]),
      .o_data  (o_data[k])
    );
  end

  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_beats = beats_q;

endmodule
`default_nettype wire

// File: tb/tb_sa_input_skew.sv
`default_nettype none
// ==== tb_sa_input_skew : scoreboard bench for the systolic input skew stage ==== rev 1.0
module tb_sa_input_skew;
  import cvxif_pkg::*;

  logic            i_clk = 1'b0;
  logic            i_rstn, i_start, i_valid, i_last;
  logic [8:0][7:0] i_data, o_data;
  logic [8:0]      o_valid;
  logic            o_busy, o_done;
  logic [15:0]     o_beats;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  typedef struct {
    int         cyc;
    int         lane;
    logic [7:0] data;
  } exp_t;
  exp_t sb[$];

  sa_input_skew #(.LANES(9), .DW(8), .CNT_W(16)) dut (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_start (i_start),
    .i_valid (i_valid),
    .i_data  (i_data),
    .i_last  (i_last),
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_beats (o_beats)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic void push_beat(input logic [8:0][7:0] d);
    for (int k = 0; k < 9; k++) sb.push_back('{cyc: cyc + 1 + k, lane: k, data: d[k]});
  endfunction

  // Lane monitor: every lane, every cycle, is either the scheduled beat or a zero bubble.
  int idx;
  always @(posedge i_clk) begin
    #2;
    for (int k = 0; k < 9; k++) begin
      idx = -1;
      for (int i = 0; i < sb.size(); i++)
        if (idx < 0 && sb[i].lane == k && sb[i].cyc == cyc) idx = i;
      total_cnt++;
      if (idx >= 0) begin
        if (o_valid[k] !== 1'b1 || o_data[k] !== sb[idx].data)
          $display("FAIL lane%0d_beat cyc=%0d: got v=%b d=%h, want v=1 d=%h", k, cyc, o_valid[k], o_data[k], sb[idx].data);
        else pass_cnt++;
        sb.delete(idx);
      end else begin
        if (o_valid[k] !== 1'b0 || o_data[k] !== 8'h00)
          $display("FAIL lane%0d_bubble cyc=%0d: got v=%b d=%h, want v=0 d=00", k, cyc, o_valid[k], o_data[k]);
        else pass_cnt++;
      end
    end
  end

  task automatic test_reset();
    i_rstn = 1'b0; i_start = 1'b0; i_valid = 1'b0; i_last = 1'b0; i_data = '0;
    #3;
    total_cnt++; if (o_valid !== 9'h0) $display("FAIL reset_valid: got %h want 000", o_valid); else pass_cnt++;
    total_cnt++; if (o_data !== '0) $display("FAIL reset_data: got %h want 0", o_data); else pass_cnt++;
    total_cnt++; if (o_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", o_busy); else pass_cnt++;
    total_cnt++; if (o_done !== 1'b0) $display("FAIL reset_done: got %b want 0", o_done); else pass_cnt++;
    total_cnt++; if (o_beats !== 16'd0) $display("FAIL reset_beats: got %0d want 0", o_beats); else pass_cnt++;
    tick(); tick();
    i_rstn = 1'b1;
    tick();
  endtask

  task automatic test_single(input bit do_start);
    int c;
    logic [8:0][7:0] d;
    if (do_start) begin
      // Beat presented together with i_start in IDLE must be dropped.
      i_start = 1'b1; i_valid = 1'b1;
      for (int k = 0; k < 9; k++) i_data[k] = 8'h55;
      tick();
      i_start = 1'b0;
    end
    for (int k = 0; k < 9; k++) d[k] = 8'(k + 1);
    i_valid = 1'b1; i_data = d; push_beat(d); c = cyc;
    total_cnt++; if (o_beats !== 16'd0) $display("FAIL single_start_beats: got %0d want 0", o_beats); else pass_cnt++;
    total_cnt++; if (o_busy !== 1'b1) $display("FAIL single_busy_open: got %b want 1", o_busy); else pass_cnt++;
    while (cyc < c + 12) begin
      tick();
      i_valid = 1'b0; i_last = (cyc == c + 1);
      total_cnt++; if (o_done !== (cyc == c + 9)) $display("FAIL single_done cyc=%0d: got %b want %b", cyc - c, o_done, (cyc == c + 9)); else pass_cnt++;
      total_cnt++; if (o_busy !== (cyc <= c + 9)) $display("FAIL single_busy cyc=%0d: got %b want %b", cyc - c, o_busy, (cyc <= c + 9)); else pass_cnt++;
    end
    i_last = 1'b0;
    total_cnt++; if (o_beats !== 16'd1) $display("FAIL single_beats: got %0d want 1", o_beats); else pass_cnt++;
    total_cnt++; if (sb.size() != 0) $display("FAIL single_sb_left: got %0d want 0", sb.size()); else pass_cnt++;
  endtask

  task automatic test_burst();
    int c;
    logic [8:0][7:0] d;
    i_start = 1'b1; tick(); i_start = 1'b0;
    c = cyc;
    for (int b = 1; b <= 4; b++) begin
      for (int k = 0; k < 9; k++) d[k] = 8'(b * 16 + k);
      i_valid = 1'b1; i_data = d; i_last = (b == 4); push_beat(d);
      tick();
    end
    i_valid = 1'b0; i_last = 1'b0;
    while (cyc < c + 14) begin
      total_cnt++; if (o_done !== (cyc == c + 12)) $display("FAIL burst_done cyc=%0d: got %b want %b", cyc - c, o_done, (cyc == c + 12)); else pass_cnt++;
      tick();
    end
    total_cnt++; if (o_beats !== 16'd4) $display("FAIL burst_beats: got %0d want 4", o_beats); else pass_cnt++;
    total_cnt++; if (o_busy !== 1'b0) $display("FAIL burst_idle_busy: got %b want 0", o_busy); else pass_cnt++;
    total_cnt++; if (sb.size() != 0) $display("FAIL burst_sb_left: got %0d want 0", sb.size()); else pass_cnt++;
  endtask

  task automatic test_bubble();
    int c;
    bit pat [3] = '{1'b1, 1'b0, 1'b1};
    sa_operand_t neg5 = -8'sd5;
    logic [8:0][7:0] d;
    i_start = 1'b1; tick(); i_start = 1'b0;
    c = cyc;
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 9; k++) d[k] = pat[b] ? neg5 : 8'h7E;
      i_valid = pat[b]; i_data = d; i_last = (b == 2);
      if (pat[b]) push_beat(d);
      tick();
    end
    i_valid = 1'b0; i_last = 1'b0;
    while (cyc < c + 13) begin
      total_cnt++; if (o_done !== (cyc == c + 11)) $display("FAIL bubble_done cyc=%0d: got %b want %b", cyc - c, o_done, (cyc == c + 11)); else pass_cnt++;
      tick();
    end
    total_cnt++; if (o_beats !== 16'd2) $display("FAIL bubble_beats: got %0d want 2", o_beats); else pass_cnt++;
    total_cnt++; if (sb.size() != 0) $display("FAIL bubble_sb_left: got %0d want 0", sb.size()); else pass_cnt++;
  endtask

  task automatic test_empty();
    i_start = 1'b1; tick(); i_start = 1'b0;
    i_last = 1'b1; tick(); i_last = 1'b0;
    total_cnt++; if (o_done !== 1'b1) $display("FAIL empty_done: got %b want 1", o_done); else pass_cnt++;
    total_cnt++; if (o_busy !== 1'b1) $display("FAIL empty_done_busy: got %b want 1", o_busy); else pass_cnt++;
    tick();
    total_cnt++; if (o_done !== 1'b0) $display("FAIL empty_done_clear: got %b want 0", o_done); else pass_cnt++;
    total_cnt++; if (o_busy !== 1'b0) $display("FAIL empty_busy_after: got %b want 0", o_busy); else pass_cnt++;
    total_cnt++; if (o_beats !== 16'd0) $display("FAIL empty_beats: got %0d want 0", o_beats); else pass_cnt++;
  endtask

  task automatic test_restart();
    int c;
    logic [8:0][7:0] d;
    i_start = 1'b1; tick(); i_start = 1'b0;
    for (int k = 0; k < 9; k++) d[k] = 8'(8'hA0 + k);
    i_valid = 1'b1; i_data = d; push_beat(d); c = cyc;
    tick(); i_valid = 1'b0; i_last = 1'b1;
    tick(); i_last = 1'b0;
    while (cyc < c + 4) begin
      total_cnt++; if (o_done !== 1'b0) $display("FAIL restart_early_done cyc=%0d: got %b want 0", cyc - c, o_done); else pass_cnt++;
      tick();
    end
    i_start = 1'b1;
    for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].cyc > cyc) sb.delete(i);
    tick(); i_start = 1'b0;
    total_cnt++; if (o_valid !== 9'h0) $display("FAIL restart_valid: got %h want 000", o_valid); else pass_cnt++;
    total_cnt++; if (o_data !== '0) $display("FAIL restart_data: got %h want 0", o_data); else pass_cnt++;
    total_cnt++; if (o_done !== 1'b0) $display("FAIL restart_done: got %b want 0", o_done); else pass_cnt++;
    total_cnt++; if (o_busy !== 1'b1) $display("FAIL restart_busy: got %b want 1", o_busy); else pass_cnt++;
    test_single(1'b0);
  endtask

  task automatic test_async_reset();
    logic [8:0][7:0] d;
    i_start = 1'b1; tick(); i_start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 9; k++) d[k] = 8'(8'h30 + b * 9 + k);
      i_valid = 1'b1; i_data = d; push_beat(d);
      tick();
    end
    #2;
    i_rstn = 1'b0;
    sb.delete();
    #1;
    total_cnt++; if (o_valid !== 9'h0) $display("FAIL areset_valid: got %h want 000", o_valid); else pass_cnt++;
    total_cnt++; if (o_data !== '0) $display("FAIL areset_data: got %h want 0", o_data); else pass_cnt++;
    total_cnt++; if (o_busy !== 1'b0) $display("FAIL areset_busy: got %b want 0", o_busy); else pass_cnt++;
    total_cnt++; if (o_beats !== 16'd0) $display("FAIL areset_beats: got %0d want 0", o_beats); else pass_cnt++;
    tick(); tick();
    i_rstn = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      total_cnt++; if (o_busy !== 1'b0) $display("FAIL areset_idle_busy n=%0d: got %b want 0", n, o_busy); else pass_cnt++;
      total_cnt++; if (o_beats !== 16'd0) $display("FAIL areset_idle_beats n=%0d: got %0d want 0", n, o_beats); else pass_cnt++;
      total_cnt++; if (o_done !== 1'b0) $display("FAIL areset_idle_done n=%0d: got %b want 0", n, o_done); else pass_cnt++;
    end
    i_valid = 1'b0;
    test_single(1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single(1'b1);
    test_burst();
    test_bubble();
    test_empty();
    test_restart();
    test_async_reset();
    tick(); tick();
    total_cnt++; if (sb.size() != 0) $display("FAIL final_sb_left: got %0d want 0", sb.size()); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
